// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock core.
// Button bit positions double as priority: the highest index wins.
package lock_pkg;

   typedef enum logic [2:0] {
      LOCKED,
      CHECK,
      UNLOCKED,
      FAIL,
      LOCKOUT
   } lock_state_t;

   localparam int DEF_DIGITS         = 4;
   localparam int DEF_DIGIT_W        = 4;
   localparam int DEF_MAX_FAILS      = 3;
   localparam int DEF_LOCKOUT_CYCLES = 100;
   localparam int DEF_UNLOCK_CYCLES  = 200;

   localparam int BTN_N      = 4;
   localparam int BTN_ENTER  = 0;
   localparam int BTN_STORE  = 1;
   localparam int BTN_SUBMIT = 2;
   localparam int BTN_CLEAR  = 3;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for N level buttons with priority resolution.
// At most one pulse bit is set per cycle; the highest set index wins.
module btn_edge #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [N-1:0] btn,
   output logic [N-1:0] pulse
);

   logic [N-1:0] btn_q;
   logic [N-1:0] btn_d;
   logic [N-1:0] rise;

   assign btn_d = btn;
   assign rise  = btn & ~btn_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn_d;
      end
   end

   always_comb begin
      pulse = '0;
      for (int i = 0; i < N; i++) begin
         if (rise[i]) begin
            pulse    = '0;
            pulse[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/code_lock_core.sv
// Combination-lock core: digit entry, code compare, fail counting with
// timed lockout, code programming and timed auto-relock.
module code_lock_core
   import lock_pkg::*;
#(
   parameter int DIGITS         = DEF_DIGITS,
   parameter int DIGIT_W        = DEF_DIGIT_W,
   parameter int MAX_FAILS      = DEF_MAX_FAILS,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
   parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [DIGIT_W-1:0]                digit_in,
   input  logic                              enter_digit,
   input  logic                              submit,
   input  logic                              store,
   input  logic                              clear,
   output logic [DIGITS*DIGIT_W-1:0]         entry,
   output logic [$clog2(DIGITS+1)-1:0]       entry_count,
   output logic                              unlocked,
   output logic                              locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
   output logic                              code_stored
);

   localparam int EW   = DIGITS * DIGIT_W;
   localparam int CW   = $clog2(DIGITS + 1);
   localparam int FW   = $clog2(MAX_FAILS + 1);
   localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   lock_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [EW-1:0] entry_q, entry_d;
   logic [EW-1:0] code_q, code_d;
   logic [CW-1:0] count_q, count_d;
   logic [FW-1:0] fail_q, fail_d;
   logic          unlocked_q, unlocked_d;
   logic          locked_out_q, locked_out_d;
   logic          code_stored_q, code_stored_d;

   logic [BTN_N-1:0] btn_raw;
   logic [BTN_N-1:0] btn_pulse;
   logic ev_enter, ev_store, ev_submit, ev_clear;
   logic full, match, store_ok, relock, lockout_done;
   logic [FW-1:0] fail_inc;
   logic [EW-1:0] shifted;

   always_comb begin
      btn_raw             = '0;
      btn_raw[BTN_ENTER]  = enter_digit;
      btn_raw[BTN_STORE]  = store;
      btn_raw[BTN_SUBMIT] = submit;
      btn_raw[BTN_CLEAR]  = clear;
   end

   btn_edge #(.N(BTN_N)) u_btn_edge (
      .clk    (clk),
      .resetn (resetn),
      .btn    (btn_raw),
      .pulse  (btn_pulse)
   );

   assign ev_enter     = btn_pulse[BTN_ENTER];
   assign ev_store     = btn_pulse[BTN_STORE];
   assign ev_submit    = btn_pulse[BTN_SUBMIT];
   assign ev_clear     = btn_pulse[BTN_CLEAR];
   assign full         = (count_q == CW'(DIGITS));
   assign match        = full && (entry_q == code_q);
   assign store_ok     = ev_store && full;
   assign relock       = ev_submit || (timer_q == TW'(UNLOCK_CYCLES - 1));
   assign lockout_done = (timer_q == TW'(LOCKOUT_CYCLES - 1));
   assign fail_inc     = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
   assign shifted      = (entry_q << DIGIT_W) | EW'(digit_in);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= LOCKED;
         timer_q       <= '0;
         entry_q       <= '0;
         code_q        <= RESET_CODE;
         count_q       <= '0;
         fail_q        <= '0;
         unlocked_q    <= 1'b0;
         locked_out_q  <= 1'b0;
         code_stored_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         entry_q       <= entry_d;
         code_q        <= code_d;
         count_q       <= count_d;
         fail_q        <= fail_d;
         unlocked_q    <= unlocked_d;
         locked_out_q  <= locked_out_d;
         code_stored_q <= code_stored_d;
      end
   end

   // The shared timer only runs in LOCKOUT and UNLOCKED and is zero on every state entry.
   always_comb begin
      state_d = state_q;
      timer_d = '0;
      case (state_q)
         LOCKED:   if (ev_submit) state_d = CHECK;
         CHECK:    state_d = match ? UNLOCKED : FAIL;
         FAIL:     state_d = (fail_inc >= FW'(MAX_FAILS)) ? LOCKOUT : LOCKED;
         LOCKOUT: begin
            if (lockout_done) state_d = LOCKED;
            else              timer_d = timer_q + TW'(1);
         end
         UNLOCKED: begin
            if (relock)         state_d = LOCKED;
            else if (!store_ok) timer_d = timer_q + TW'(1);
         end
         default:  state_d = LOCKED;
      endcase
   end

   always_comb begin
      entry_d       = entry_q;
      count_d       = count_q;
      code_d        = code_q;
      fail_d        = fail_q;
      code_stored_d = 1'b0;
      case (state_q)
         LOCKED, UNLOCKED: begin
            if (state_q == UNLOCKED && relock) begin
               entry_d = '0;
               count_d = '0;
            end else if (state_q == UNLOCKED && store_ok) begin
               code_d        = entry_q;
               code_stored_d = 1'b1;
               entry_d       = '0;
               count_d       = '0;
            end else if (ev_clear) begin
               entry_d = '0;
               count_d = '0;
            end else if (ev_enter && !full) begin
               entry_d = shifted;
               count_d = count_q + CW'(1);
            end
         end
         CHECK:   if (match) fail_d = '0;
         FAIL: begin
            fail_d  = fail_inc;
            entry_d = '0;
            count_d = '0;
         end
         LOCKOUT: begin
            entry_d = '0;
            count_d = '0;
            if (lockout_done) fail_d = '0;
         end
         default: ;
      endcase
      unlocked_d   = (state_d == UNLOCKED);
      locked_out_d = (state_d == LOCKOUT);
   end

   assign entry       = entry_q;
   assign entry_count = count_q;
   assign unlocked    = unlocked_q;
   assign locked_out  = locked_out_q;
   assign fail_count  = fail_q;
   assign code_stored = code_stored_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Directed-plus-random bench for code_lock_core against a digit-queue model
// of the lock (entered symbols, stored code, fail count, lock mode).
module tb_code_lock_core;

   localparam int DIGITS         = 4;
   localparam int DIGIT_W        = 4;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 100;
   localparam int UNLOCK_CYCLES  = 200;
   localparam int EW             = DIGITS * DIGIT_W;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef digit_t code_t [DIGITS];

   logic          clk;
   logic          resetn;
   digit_t        digit_in;
   logic          enter_digit, submit, store, clear;
   logic [EW-1:0] entry;
   logic [2:0]    entry_count;
   logic          unlocked, locked_out;
   logic [1:0]    fail_count;
   logic          code_stored;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rise_cyc = 0;
   int lk_cyc   = 0;

   digit_t model_q[$];
   code_t  model_code;
   int     model_fail;
   bit     model_unl;
   bit     model_lko;

   code_t  c1, c2, zeros;

   code_lock_core #(
      .DIGITS         (DIGITS),
      .DIGIT_W        (DIGIT_W),
      .MAX_FAILS      (MAX_FAILS),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .UNLOCK_CYCLES  (UNLOCK_CYCLES),
      .RESET_CODE     ('0)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .digit_in    (digit_in),
      .enter_digit (enter_digit),
      .submit      (submit),
      .store       (store),
      .clear       (clear),
      .entry       (entry),
      .entry_count (entry_count),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .fail_count  (fail_count),
      .code_stored (code_stored)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] model_entry();
      logic [EW-1:0] e = '0;
      foreach (model_q[i]) e = (e << DIGIT_W) | EW'(model_q[i]);
      return e;
   endfunction

   function automatic bit model_match();
      if (model_q.size() != DIGITS) return 1'b0;
      foreach (model_code[i]) if (model_q[i] != model_code[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      model_q.delete();
      foreach (model_code[i]) model_code[i] = '0;
      model_fail = 0;
      model_unl  = 1'b0;
      model_lko  = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check_output({tag, "_entry"},    entry,       model_entry());
      check_output({tag, "_count"},    entry_count, model_q.size());
      check_output({tag, "_fails"},    fail_count,  model_fail);
      check_output({tag, "_unlocked"}, unlocked,    model_unl);
      check_output({tag, "_lockout"},  locked_out,  model_lko);
   endtask

   task automatic press_digit(input digit_t d);
      digit_in    = d;
      enter_digit = 1'b1;
      tick();
      if (!model_lko && model_q.size() < DIGITS) model_q.push_back(d);
      check_model("digit");
      enter_digit = 1'b0;
      tick();
   endtask

   task automatic press_clear();
      clear = 1'b1;
      tick();
      if (!model_lko) model_q.delete();
      check_model("clear");
      clear = 1'b0;
      tick();
   endtask

   task automatic enter_code(input code_t c);
      foreach (c[i]) press_digit(c[i]);
   endtask

   // From LOCKED: compare then unlock or fail; from UNLOCKED: relock.
   task automatic press_submit();
      bit ok;
      if (model_unl) begin
         submit = 1'b1;
         tick();
         model_unl = 1'b0;
         model_q.delete();
         check_model("relock");
         submit = 1'b0;
         tick();
      end else begin
         ok     = model_match();
         submit = 1'b1;
         tick();
         check_output("submit_t1_unlocked", unlocked, 1'b0);
         submit = 1'b0;
         tick();
         check_output("submit_t2_unlocked", unlocked, ok);
         if (ok) begin
            rise_cyc   = cyc;
            model_unl  = 1'b1;
            model_fail = 0;
         end
         tick();
         if (!ok) begin
            model_fail++;
            model_q.delete();
            if (model_fail >= MAX_FAILS) begin
               model_lko = 1'b1;
               lk_cyc    = cyc;
            end
         end
         check_model("submit_t3");
      end
   endtask

   task automatic press_store();
      bit stored;
      store = 1'b1;
      tick();
      stored = model_unl && (model_q.size() == DIGITS);
      check_output("store_pulse", code_stored, stored);
      if (stored) begin
         foreach (model_code[i]) model_code[i] = model_q[i];
         model_q.delete();
      end
      check_model("store");
      store = 1'b0;
      tick();
      check_output("store_pulse_once", code_stored, 1'b0);
   endtask

   task automatic wrong_attempt();
      code_t w;
      foreach (w[i]) w[i] = digit_t'($urandom_range(0, 15));
      w[DIGITS-1] = model_code[DIGITS-1] ^ digit_t'($urandom_range(1, 15));
      press_clear();
      enter_code(w);
      press_submit();
   endtask

   task automatic wait_relock(input int span);
      for (int g = 0; g < 1000 && unlocked === 1'b1; g++) tick();
      check_output("relock_span", cyc - rise_cyc, span);
      model_unl = 1'b0;
      model_q.delete();
      check_model("auto_relock");
   endtask

   task automatic wait_lockout();
      for (int g = 0; g < 1000 && locked_out === 1'b1; g++) tick();
      check_output("lockout_span", cyc - lk_cyc, LOCKOUT_CYCLES);
      model_lko  = 1'b0;
      model_fail = 0;
      check_model("lockout_end");
   endtask

   initial begin
      resetn      = 1'b0;
      digit_in    = '0;
      enter_digit = 1'b0;
      submit      = 1'b0;
      store       = 1'b0;
      clear       = 1'b0;
      foreach (zeros[i]) zeros[i] = '0;
      model_reset();
      repeat (3) tick();
      check_model("reset");
      check_output("reset_code_stored", code_stored, 1'b0);

      // A button held across reset release counts once.
      enter_digit = 1'b1;
      digit_in    = '0;
      resetn      = 1'b1;
      tick();
      model_q.push_back('0);
      check_model("held_release");
      enter_digit = 1'b0;
      tick();
      repeat (DIGITS - 1) press_digit('0);
      press_submit();

      foreach (c1[i]) c1[i] = digit_t'($urandom_range(0, 15));
      press_clear();
      enter_code(c1);
      press_store();
      press_submit();
      enter_code(c1);
      press_submit();
      press_submit();

      for (int k = 0; k < MAX_FAILS; k++) wrong_attempt();
      repeat (3) press_digit(digit_t'($urandom_range(0, 15)));
      wait_lockout();

      press_digit('0);
      press_digit('0);
      press_submit();
      for (int k = 0; k < DIGITS + 1; k++) press_digit(digit_t'($urandom_range(0, 15)));
      press_clear();
      enter_code(c1);
      press_submit();
      wait_relock(UNLOCK_CYCLES);

      enter_code(c1);
      press_submit();
      foreach (c2[i]) c2[i] = digit_t'($urandom_range(0, 15));
      press_clear();
      enter_code(c2);
      while (cyc < rise_cyc + 149) tick();
      press_store();
      wait_relock(UNLOCK_CYCLES + 150);

      press_digit(digit_t'($urandom_range(0, 15)));
      press_digit(digit_t'($urandom_range(0, 15)));
      clear       = 1'b1;
      enter_digit = 1'b1;
      digit_in    = digit_t'($urandom_range(0, 15));
      tick();
      model_q.delete();
      check_model("clear_vs_digit");
      clear       = 1'b0;
      enter_digit = 1'b0;
      tick();

      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) press_clear();
         else press_digit(digit_t'($urandom_range(0, 15)));
      end
      press_clear();
      if ($urandom_range(0, 1) == 1) enter_code(c2);
      else for (int k = 0; k < DIGITS; k++) press_digit(digit_t'($urandom_range(0, 15)));
      press_submit();
      if (model_unl) press_submit();

      for (int k = 0; k < MAX_FAILS && !model_lko; k++) wrong_attempt();
      repeat (5) tick();
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      check_model("async_reset");
      check_output("async_reset_code_stored", code_stored, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();
      enter_code(zeros);
      press_submit();
      check_output("reset_code_unlocks", unlocked, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
